puf_resp_reader: RTL



---
 rtl/puf_resp_reader_pkg.sv | 28 ++
 rtl/puf_resp_reader_valid_sync.sv | 36 +++
 rtl/puf_resp_reader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/puf_resp_reader_pkg.sv
// Shared definitions for the ring-oscillator PUF response reader and its integration top.
package puf_resp_reader_pkg;

  // Controller state encoding, fixed so the integration top can decode it.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMeas = 3'd1,
    StGap  = 3'd2,
    StCmp  = 3'd3,
    StOut  = 3'd4
  } puf_state_e;

  // Which evaluation of the current pair is being measured.
  typedef enum logic {
    PhaseA = 1'b0,
    PhaseB = 1'b1
  } puf_phase_e;

  // Default count field width and the resulting metric width {count_set, count}.
  localparam int unsigned PufCntBitSize = 5;
  localparam int unsigned PufMetricW    = 2 * PufCntBitSize;

  // Metric width for an arbitrary count field width.
  function automatic int unsigned puf_metric_w(input int unsigned cnt_bits);
    return 2 * cnt_bits;
  endfunction

endpackage

// File: rtl/puf_resp_reader_valid_sync.sv
// Two-flop synchronizer with a rising-edge detector for signals from the oscillator domain.
module puf_valid_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  input  logic clr_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  // Two-stage synchronizer; never cleared so a clear cannot fabricate an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  // Edge history; preset high while cleared so a level already present at entry is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (clr_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q & ~clr_i;

endmodule

// File: rtl/puf_resp_reader.sv
// PUF controller: runs pairs of evaluations, compares them and packs the bits into a word.
module puf_resp_reader
  import puf_resp_reader_pkg::*;
#(
  parameter int unsigned CNT_BIT_SIZE = 5,
  parameter int unsigned RESP_BITS    = 8,
  parameter int unsigned GAP_CYC      = 2,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_puf_valid,
  input  logic [CNT_BIT_SIZE-1:0] i_puf_count,
  input  logic [CNT_BIT_SIZE-1:0] i_puf_count_set,
  input  logic                    i_resp_ready,
  output logic                    o_puf_en,
  output logic                    o_busy,
  output logic                    o_resp_valid,
  output logic [RESP_BITS-1:0]    o_resp,
  output logic                    o_timeout
);

  localparam int unsigned MetricW = puf_metric_w(CNT_BIT_SIZE);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYC);
  localparam int unsigned GapW    = $clog2(GAP_CYC + 1);
  localparam int unsigned IdxW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(RESP_BITS - 1);

  puf_state_e           state_q, state_d;
  puf_phase_e           phase_q, phase_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [MetricW-1:0]   a_q, a_d, b_q, b_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 timeout_q, timeout_d;

  logic               valid_rise;
  logic               sync_clr;
  logic [MetricW-1:0] metric;

  // count_set occupies the upper half so it dominates the comparison.
  assign metric = {i_puf_count_set, i_puf_count};

  puf_valid_sync u_valid_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(i_puf_valid),
    .clr_i  (sync_clr),
    .rise_o (valid_rise)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = StMeas;
      StMeas: begin
        if (valid_rise) begin
          state_d = (phase_q == PhaseA) ? StGap : StCmp;
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end
      end
      StGap:  if (gap_cnt_q == GapLast) state_d = StMeas;
      StCmp:  state_d = (idx_q == IdxLast) ? StOut : StGap;
      StOut:  if (i_resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    o_puf_en     = (state_q == StMeas);
    o_busy       = (state_q != StIdle);
    o_resp_valid = (state_q == StOut);
    sync_clr     = (state_q != StMeas);
  end

  // Datapath next-state: counters, captured metrics and the response word.
  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          idx_d     = '0;
          phase_d   = PhaseA;
          resp_d    = '0;
          timeout_d = 1'b0;
          to_cnt_d  = '0;
        end
      end
      StMeas: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (valid_rise) begin
          if (phase_q == PhaseA) begin
            a_d       = metric;
            phase_d   = PhaseB;
            gap_cnt_d = '0;
          end else begin
            b_d = metric;
          end
        end else if (to_cnt_q == ToLast) begin
          timeout_d = 1'b1;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapLast) to_cnt_d = '0;
      end
      StCmp: begin
        // Ties resolve to 0.
        resp_d[idx_q] = (a_q > b_q);
        if (idx_q != IdxLast) begin
          idx_d     = idx_q + 1'b1;
          phase_d   = PhaseA;
          gap_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PhaseA;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_resp    = resp_q;
  assign o_timeout = timeout_q;

endmodule
